hit_resolver: RTL

- Combat referee between the two player FSMs and the display/HUD.
- Each cycle, tests each player's active hitbox against the opponent's main hurtbox.
- Issues one-cycle hitFlag pulses to the victim and owns health and block meters for both players.
- Detects game over and freezes combat until reset.

---
 rtl/hit_resolver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hit_resolver.sv
// Combat referee: hitbox/hurtbox overlap, hit pulses, health/block meters, game over.
// Define HIT_RESOLVER_CHIP_DAMAGE_EN to make blocked directional hits cost 1 health.
module hit_resolver #(
    parameter int MAX_HEALTH   = 5,
    parameter int MAX_BLOCK    = 3,
    parameter int BASIC_DMG    = 1,
    parameter int DIR_DMG      = 2,
    parameter int REGEN_CYCLES = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  p1_state,
    input  logic [3:0]  p2_state,
    input  logic [39:0] p1_basic_box,
    input  logic [39:0] p1_dir_box,
    input  logic [39:0] p1_main_box,
    input  logic [39:0] p2_basic_box,
    input  logic [39:0] p2_dir_box,
    input  logic [39:0] p2_main_box,
    output logic [1:0]  p1_hitFlag,
    output logic [1:0]  p2_hitFlag,
    output logic [2:0]  p1_health,
    output logic [2:0]  p2_health,
    output logic [2:0]  p1_block,
    output logic [2:0]  p2_block,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam int CW = $clog2(REGEN_CYCLES);
    localparam logic [CW-1:0] REGEN_LAST = CW'(REGEN_CYCLES - 1);
    localparam logic [2:0] HEALTH_MAX = 3'(MAX_HEALTH);
    localparam logic [2:0] BLOCK_MAX  = 3'(MAX_BLOCK);

    localparam logic [3:0] S_MOVEBACK  = 4'd2;
    localparam logic [3:0] S_B_END     = 4'd4;
    localparam logic [3:0] S_D_END     = 4'd7;
    localparam logic [3:0] S_HITSTUN   = 4'd9;
    localparam logic [3:0] S_BLOCKSTUN = 4'd10;

    typedef enum logic {FIGHT, OVER} fsm_t;

    fsm_t          fsm;
    logic          p1_conn, p2_conn;
    logic          p1_blk_q, p2_blk_q;
    logic [CW-1:0] p1_cnt, p2_cnt;
    logic [1:0]    hit_p1, hit_p2;
    logic          blk_p1, blk_p2;
    logic          p1_swing, p2_swing;
    logic [2:0]    nh1, nh2;
    logic          go_over;

    // Boxes are packed {x1,x2,y1,y2}; edges touching count as overlap.
    function automatic logic overlap(input logic [39:0] a, input logic [39:0] b);
        return (a[39:30] <= b[29:20]) && (b[39:30] <= a[29:20]) &&
               (a[19:10] <= b[9:0])   && (b[19:10] <= a[9:0]);
    endfunction

    function automatic logic [1:0] strike(
        input logic [3:0]  st,
        input logic [39:0] basic,
        input logic [39:0] dir,
        input logic [39:0] victim
    );
        logic [1:0] r;
        r = 2'b00;
        unique case (1'b1)
            (st == S_B_END): r = overlap(basic, victim) ? 2'b01 : 2'b00;
            (st == S_D_END): r = overlap(dir, victim) ? 2'b10 : 2'b00;
            default:         r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] next_health(
        input logic [2:0] h,
        input logic [1:0] flag,
        input logic       blk
    );
        logic [2:0] dmg;
        dmg = 3'd0;
        if (flag == 2'b01 && !blk)
            dmg = 3'(BASIC_DMG);
        else if (flag == 2'b10 && !blk)
            dmg = 3'(DIR_DMG);
`ifdef HIT_RESOLVER_CHIP_DAMAGE_EN
        else if (flag == 2'b10)
            dmg = 3'd1;
`endif
        return (h > dmg) ? h - dmg : 3'd0;
    endfunction

    function automatic logic [2:0] next_block(
        input logic [2:0]    b,
        input logic [1:0]    flag,
        input logic          blk,
        input logic [CW-1:0] cnt
    );
        if (flag != 2'b00)
            return (blk && b != 3'd0) ? b - 3'd1 : b;
        if (b < BLOCK_MAX && cnt == REGEN_LAST)
            return b + 3'd1;
        return b;
    endfunction

    function automatic logic [CW-1:0] next_cnt(
        input logic [2:0]    b,
        input logic [1:0]    flag,
        input logic [CW-1:0] cnt
    );
        if (flag != 2'b00 || b >= BLOCK_MAX || cnt == REGEN_LAST)
            return '0;
        return cnt + CW'(1);
    endfunction

    function automatic logic invuln(input logic [3:0] st);
        return (st == S_HITSTUN) || (st == S_BLOCKSTUN);
    endfunction

    assign p1_swing = (p1_state == S_B_END) || (p1_state == S_D_END);
    assign p2_swing = (p2_state == S_B_END) || (p2_state == S_D_END);

    assign hit_p2 = (fsm == FIGHT && !p1_conn && !invuln(p2_state)) ?
                    strike(p1_state, p1_basic_box, p1_dir_box, p2_main_box) : 2'b00;
    assign hit_p1 = (fsm == FIGHT && !p2_conn && !invuln(p1_state)) ?
                    strike(p2_state, p2_basic_box, p2_dir_box, p1_main_box) : 2'b00;

    assign blk_p1 = (p1_state == S_MOVEBACK) && (p1_block != 3'd0);
    assign blk_p2 = (p2_state == S_MOVEBACK) && (p2_block != 3'd0);

    // The registered hitFlag doubles as the pending-damage record.
    assign nh1 = next_health(p1_health, p1_hitFlag, p1_blk_q);
    assign nh2 = next_health(p2_health, p2_hitFlag, p2_blk_q);
    assign go_over = (fsm == FIGHT) && (nh1 == 3'd0 || nh2 == 3'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm        <= FIGHT;
            p1_hitFlag <= 2'b00;
            p2_hitFlag <= 2'b00;
            p1_health  <= HEALTH_MAX;
            p2_health  <= HEALTH_MAX;
            p1_block   <= BLOCK_MAX;
            p2_block   <= BLOCK_MAX;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            p1_conn    <= 1'b0;
            p2_conn    <= 1'b0;
            p1_blk_q   <= 1'b0;
            p2_blk_q   <= 1'b0;
            p1_cnt     <= '0;
            p2_cnt     <= '0;
        end else begin
            p1_conn <= p1_swing ? (p1_conn || hit_p2 != 2'b00) : 1'b0;
            p2_conn <= p2_swing ? (p2_conn || hit_p1 != 2'b00) : 1'b0;
            if (fsm == FIGHT) begin
                p1_hitFlag <= go_over ? 2'b00 : hit_p1;
                p2_hitFlag <= go_over ? 2'b00 : hit_p2;
                p1_blk_q   <= blk_p1;
                p2_blk_q   <= blk_p2;
                p1_health  <= nh1;
                p2_health  <= nh2;
                p1_block   <= next_block(p1_block, p1_hitFlag, p1_blk_q, p1_cnt);
                p2_block   <= next_block(p2_block, p2_hitFlag, p2_blk_q, p2_cnt);
                p1_cnt     <= next_cnt(p1_block, p1_hitFlag, p1_cnt);
                p2_cnt     <= next_cnt(p2_block, p2_hitFlag, p2_cnt);
                if (go_over) begin
                    fsm       <= OVER;
                    game_over <= 1'b1;
                    winner    <= {nh1 == 3'd0, nh2 == 3'd0};
                end
            end else begin
                p1_hitFlag <= 2'b00;
                p2_hitFlag <= 2'b00;
            end
        end
    end

endmodule
